// File: rtl/etroc_ro_pkg.sv
// Shared types and helpers for the ETROC readout sequencer.
package etroc_ro_pkg;

  localparam int RO_ADDR_BITS  = 8;
  localparam int RO_DATA_BITS  = 30;
  localparam int RO_L1_LATENCY = 100;

  localparam logic [3:0] TRAILER_TAG = 4'hA;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    CAP,
    EMIT,
    DONE
  } ro_state_t;

  function automatic int roi_idx(input int row, input int col);
    return 4 * row + col;
  endfunction

  // Lowest set bit of mask at or above start, returned as {found, index}.
  function automatic logic [2:0] first_from(input logic [3:0] mask, input logic [2:0] start);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (i >= int'(start))) res = {1'b1, i[1:0]};
    end
    return res;
  endfunction

  function automatic logic [3:0] row_bits(input logic [15:0] mask, input logic [1:0] row);
    return mask[roi_idx(int'(row), 0) +: 4];
  endfunction

endpackage

// File: rtl/etroc_ro_ctrl_if.sv
// Bus between the readout sequencer and the 4x4 pixel RAM array.
interface etroc_ro_ctrl_if #(
  parameter int ADDR_BITS = etroc_ro_pkg::RO_ADDR_BITS,
  parameter int DATA_BITS = etroc_ro_pkg::RO_DATA_BITS
);

  logic                 we;
  logic [ADDR_BITS-1:0] addr;
  logic [3:0]           roe;
  logic [DATA_BITS-1:0] din0;
  logic [DATA_BITS-1:0] din1;
  logic [DATA_BITS-1:0] din2;
  logic [DATA_BITS-1:0] din3;

  modport master (output we, addr, roe, input din0, din1, din2, din3);
  modport slave  (input we, addr, roe, output din0, din1, din2, din3);

endinterface

// File: rtl/etroc_ro_ctrl_wptr.sv
// Free-running circular-buffer write pointer shared by all pixel RAMs.
module etroc_ro_ctrl_wptr
  import etroc_ro_pkg::*;
#(
  parameter int ADDR_BITS = RO_ADDR_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 bc0,
  output logic [ADDR_BITS-1:0] wptr
);

  // Keeps counting during readout; bc0 resynchronises to zero.
  always_ff @(posedge clock) begin
    if (reset)    wptr <= '0;
    else if (bc0) wptr <= '0;
    else          wptr <= wptr + ADDR_BITS'(1);
  end

endmodule

// File: rtl/etroc_ro_ctrl.sv
// ETROC 4x4 readout sequencer: freezes RAM writes on l1acc and streams ROI pixels.
// Optional trailer word in DONE when ETROC_RO_TRAILER_EN is defined.
module etroc_ro_ctrl
  import etroc_ro_pkg::*;
#(
  parameter int ADDR_BITS  = RO_ADDR_BITS,
  parameter int DATA_BITS  = RO_DATA_BITS,
  parameter int L1_LATENCY = RO_L1_LATENCY
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 l1acc,
  input  logic                 bc0,
  input  logic [15:0]          roi,
  etroc_ro_ctrl_if.master      ram,
  output logic [DATA_BITS-1:0] dout
);

  ro_state_t            state, state_d;
  logic [ADDR_BITS-1:0] wptr;
  logic [ADDR_BITS-1:0] trig, trig_d;
  logic [15:0]          roi_cap, roi_d;
  logic [1:0]           row, row_d;
  logic [1:0]           col, col_d;
  logic [DATA_BITS-1:0] rowbuf [4];

  logic                 we_q, we_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [3:0]           roe_q, roe_d;
  logic [DATA_BITS-1:0] dout_d;
  logic                 readout;

  logic [3:0] rows_live, rows_cap;
  logic [2:0] first_row, next_row, first_col, next_col;

  etroc_ro_ctrl_wptr #(.ADDR_BITS(ADDR_BITS)) u_wptr (
    .clock (clock),
    .reset (reset),
    .bc0   (bc0),
    .wptr  (wptr)
  );

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      rows_live[r] = |row_bits(roi, 2'(r));
      rows_cap[r]  = |row_bits(roi_cap, 2'(r));
    end
  end

  assign first_row = first_from(rows_live, 3'd0);
  assign next_row  = first_from(rows_cap, {1'b0, row} + 3'd1);
  assign first_col = first_from(row_bits(roi_cap, row), 3'd0);
  assign next_col  = first_from(row_bits(roi_cap, row), {1'b0, col} + 3'd1);

`ifdef ETROC_RO_TRAILER_EN
  logic [29:0] trailer;
  assign trailer = {TRAILER_TAG, 8'(trig), roi_cap, 2'b00};
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      trig    <= '0;
      roi_cap <= '0;
      row     <= '0;
      col     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      roe_q   <= '0;
      dout    <= '0;
    end else begin
      state   <= state_d;
      trig    <= trig_d;
      roi_cap <= roi_d;
      row     <= row_d;
      col     <= col_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      roe_q   <= roe_d;
      dout    <= dout_d;
    end
  end

  // The enabled row drives the column buses while in CAP; latch it on leaving.
  always_ff @(posedge clock) begin
    if (state == CAP) begin
      rowbuf[0] <= ram.din0;
      rowbuf[1] <= ram.din1;
      rowbuf[2] <= ram.din2;
      rowbuf[3] <= ram.din3;
    end
  end

  always_comb begin
    state_d = state;
    trig_d  = trig;
    roi_d   = roi_cap;
    row_d   = row;
    col_d   = col;
    case (state)
      IDLE: begin
        if (l1acc) begin
          trig_d = wptr - ADDR_BITS'(L1_LATENCY);
          roi_d  = roi;
          if (first_row[2]) begin
            row_d   = first_row[1:0];
            state_d = SEL;
          end
`ifdef ETROC_RO_TRAILER_EN
          else begin
            state_d = DONE;
          end
`endif
        end
      end
      SEL:  state_d = CAP;
      CAP: begin
        col_d   = first_col[1:0];
        state_d = EMIT;
      end
      EMIT: begin
        if (next_col[2]) begin
          col_d = next_col[1:0];
        end else if (next_row[2]) begin
          row_d   = next_row[1:0];
          state_d = SEL;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Words leave one cycle after their EMIT slot, so DONE's word lands after DONE too.
  always_comb begin
    readout = (state != IDLE) || (state_d == SEL);
    we_d    = !readout;
    addr_d  = readout ? trig_d : wptr;
    roe_d   = '0;
    if ((state_d == SEL) || (state_d == CAP)) roe_d = 4'b0001 << row_d;
    dout_d  = '0;
    if (state == EMIT) dout_d = rowbuf[col];
`ifdef ETROC_RO_TRAILER_EN
    if (state == DONE) dout_d = DATA_BITS'(trailer);
`endif
  end

  assign ram.we   = we_q;
  assign ram.addr = addr_q;
  assign ram.roe  = roe_q;

endmodule

// File: tb/tb_etroc_ro_ctrl.sv
// Scoreboard bench for etroc_ro_ctrl: per-cycle expected outputs from a timeline model,
// with a synchronous-read pixel RAM model behind the column buses.
module tb_etroc_ro_ctrl;
  import etroc_ro_pkg::*;

  localparam int AB  = 8;
  localparam int DB  = 30;
  localparam int LAT = 100;
`ifdef ETROC_RO_TRAILER_EN
  localparam bit TRAILER_ON = 1'b1;
`else
  localparam bit TRAILER_ON = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          l1acc = 1'b0;
  logic          bc0   = 1'b0;
  logic [15:0]   roi   = 16'h0;
  logic [DB-1:0] dout;

  etroc_ro_ctrl_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) ram_bus ();

  etroc_ro_ctrl #(.ADDR_BITS(AB), .DATA_BITS(DB), .L1_LATENCY(LAT)) dut (
    .clock (clock),
    .reset (reset),
    .l1acc (l1acc),
    .bc0   (bc0),
    .roi   (roi),
    .ram   (ram_bus),
    .dout  (dout)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic          we;
    logic [AB-1:0] addr;
    logic [3:0]    roe;
    logic [DB-1:0] dout;
  } rec_t;

  rec_t          exp_q[$];
  rec_t          pend[$];
  logic [DB-1:0] mem [16][256];
  logic [DB-1:0] rdata [16];
  logic [AB-1:0] wptr_m = '0;
  int            checks = 0;
  int            errors = 0;

  // Pixel RAM model: synchronous read, content static for the whole run.
  always @(posedge clock) begin
    for (int p = 0; p < 16; p++) rdata[p] <= mem[p][ram_bus.addr];
  end

  always_comb begin
    ram_bus.din0 = '0;
    ram_bus.din1 = '0;
    ram_bus.din2 = '0;
    ram_bus.din3 = '0;
    for (int r = 0; r < 4; r++) begin
      if (ram_bus.roe[r]) begin
        ram_bus.din0 = ram_bus.din0 | rdata[4*r];
        ram_bus.din1 = ram_bus.din1 | rdata[4*r+1];
        ram_bus.din2 = ram_bus.din2 | rdata[4*r+2];
        ram_bus.din3 = ram_bus.din3 | rdata[4*r+3];
      end
    end
  end

  function automatic rec_t mk(input logic w, input logic [AB-1:0] a, input logic [3:0] oe,
                              input logic [DB-1:0] d);
    rec_t rr;
    rr.we = w; rr.addr = a; rr.roe = oe; rr.dout = d;
    return rr;
  endfunction

  // Timeline of one readout: per enabled row 2 cycles of roe, then one slot per pixel,
  // then DONE; each word shows up one cycle after its slot.
  task automatic plan_readout(input logic [AB-1:0] trig, input logic [15:0] r,
                              input logic [AB-1:0] w_now);
    logic [3:0]    roe_s[$];
    logic [DB-1:0] word_s[$];
    logic [DB-1:0] trl;
    trl = TRAILER_ON ? {4'hA, trig, r, 2'b00} : '0;
    if (r == 16'h0) begin
      if (TRAILER_ON) begin
        pend.push_back(mk(1'b1, w_now, 4'h0, '0));
        pend.push_back(mk(1'b0, trig, 4'h0, trl));
      end
      return;
    end
    for (int row = 0; row < 4; row++) begin
      if (r[4*row +: 4] == 4'h0) continue;
      repeat (2) begin
        roe_s.push_back(4'b0001 << row);
        word_s.push_back('0);
      end
      for (int col = 0; col < 4; col++) begin
        if (r[4*row+col]) begin
          roe_s.push_back(4'h0);
          word_s.push_back(mem[4*row+col][trig]);
        end
      end
    end
    roe_s.push_back(4'h0);
    word_s.push_back(trl);
    for (int i = 0; i <= roe_s.size(); i++) begin
      pend.push_back(mk(1'b0, trig, (i < roe_s.size()) ? roe_s[i] : 4'h0,
                        (i > 0) ? word_s[i-1] : '0));
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic l1, input logic b,
                               input logic [15:0] r);
    rec_t rec;
    reset = rst;
    l1acc = l1;
    bc0   = b;
    roi   = r;
    @(posedge clock);
    if (rst) begin
      pend.delete();
      rec    = mk(1'b0, '0, 4'h0, '0);
      wptr_m = '0;
    end else begin
      if ((pend.size() == 0) && l1) plan_readout(wptr_m - AB'(LAT), r, wptr_m);
      rec    = (pend.size() > 0) ? pend.pop_front() : mk(1'b1, wptr_m, 4'h0, '0);
      wptr_m = b ? '0 : wptr_m + 1'b1;
    end
    exp_q.push_back(rec);
    @(negedge clock);
  endtask

  task automatic check_field(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s at t=%0t: got %h, expected %h", name, $time, got, want);
    end
  endtask

  task automatic checkOutput(input rec_t e);
    check_field("we",   32'(ram_bus.we),   32'(e.we));
    check_field("addr", 32'(ram_bus.addr), 32'(e.addr));
    check_field("roe",  32'(ram_bus.roe),  32'(e.roe));
    check_field("dout", 32'(dout),         32'(e.dout));
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  task automatic drain();
    for (int n = 0; n < 64 && pend.size() > 0; n++) applyStimulus(1'b0, 1'b0, 1'b0, 16'($urandom));
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    logic        rst, l1, b;
    logic [15:0] r;
    for (int p = 0; p < 16; p++)
      for (int a = 0; a < 256; a++) mem[p][a] = 30'($urandom);
    mem[0][50] = 30'h1234567;

    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);

    for (int n = 0; n < 300 && wptr_m != 8'd150; n++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0001);
    drain();

    applyStimulus(1'b0, 1'b1, 1'b0, 16'h8421);
    drain();

    applyStimulus(1'b0, 1'b1, 1'b0, 16'hFFFF);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h00F0);
    drain();

    for (int n = 0; n < 300 && wptr_m != 8'd10; n++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0024);
    drain();
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);

    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    drain();
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);

    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 499) == 0);
      l1  = ($urandom_range(0, 5) == 0);
      b   = ($urandom_range(0, 99) == 0);
      case ($urandom_range(0, 3))
        0:       r = 16'h0000;
        1:       r = 16'h0001 << $urandom_range(0, 15);
        2:       r = 16'($urandom);
        default: r = 16'hFFFF;
      endcase
      applyStimulus(rst, l1, b, r);
    end
    drain();

    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
